// File: rtl/binary_mul_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package binary_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int W_DEF       = 4;
  localparam int MUL_LAT_DEF = 1;
  localparam int NUM_REQ_DEF = 4;

  // Index width for a range of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_REQ_DEF);

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Combinational rotating-priority arbiter: first requester at or above ptr, wrapping.
module rr_arbiter_ptr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gidx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/binary_mul_rr_sched.sv
// Shares one external registered multiplier among NUM_REQ requesters, one op in flight.
module binary_mul_rr_sched
  import binary_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [2*W-1:0]       rsp_p,
  output logic                 busy,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  output logic                 mul_en,
  input  logic [2*W-1:0]       mul_p
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(MUL_LAT);

  state_t               state, state_nxt;
  logic [IW-1:0]        ptr, gidx, g;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   gnt, gidx_oh;
  logic                 accept, rsp_done;

  rr_arbiter_ptr #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .gnt  (gnt),
    .gidx (g)
  );

  // Gate with rst_n so no requester sees a handshake while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign accept    = (state == IDLE) && (|req_valid);
  assign gidx_oh   = NUM_REQ'(1) << gidx;
  assign rsp_valid = (state == RESP) ? gidx_oh : '0;
  assign rsp_done  = (state == RESP) && rsp_ready[gidx];
  assign mul_en    = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      rsp_p <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mul_a <= req_a[int'(g)*W +: W];
        mul_b <= req_b[int'(g)*W +: W];
        gidx  <= g;
        ptr   <= (int'(g) == NUM_REQ-1) ? '0 : g + IW'(1);
      end
      if (state == ISSUE) cnt <= CW'(MUL_LAT-1);
      if (state == WAIT) begin
        if (cnt == '0) rsp_p <= mul_p;
        else           cnt   <= cnt - CW'(1);
      end
    end
  end

endmodule
